// File: rtl/pe_req_conditioner_pkg.sv
// Shared constants for the priority-encoder request conditioner.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pe_pkg;

  localparam int PE_WIDTH            = 8;
  localparam int PE_DEBOUNCE_DEFAULT = 4;

  // Per-bit mode encoding used on edge_mode_i.
  localparam logic PE_MODE_LEVEL = 1'b0;
  localparam logic PE_MODE_EDGE  = 1'b1;

endpackage

// File: rtl/pe_req_conditioner_if.sv
// Request/mode/clear inputs and conditioned request outputs of the conditioner.
// Latency: none (wiring only).
// Backpressure: none; requests are levels or latched pending bits, never handshaked.
// Ports: req_raw_i/edge_mode_i/clr_i/en_i toward the conditioner;
//        req_o/any_o/ovf_o/new_o back toward the encoder side.
interface pe_req_conditioner_if
  import pe_pkg::*;
#(
  parameter int WIDTH = PE_WIDTH
);

  logic [WIDTH-1:0] req_raw_i;
  logic [WIDTH-1:0] edge_mode_i;
  logic [WIDTH-1:0] clr_i;
  logic             en_i;
  logic [WIDTH-1:0] req_o;
  logic             any_o;
  logic [WIDTH-1:0] ovf_o;
  logic             new_o;

  modport master (
    output req_raw_i, edge_mode_i, clr_i, en_i,
    input  req_o, any_o, ovf_o, new_o
  );

  modport slave (
    input  req_raw_i, edge_mode_i, clr_i, en_i,
    output req_o, any_o, ovf_o, new_o
  );

endinterface

// File: rtl/pe_req_conditioner_bit_filter.sv
// One request line: 2-flop synchroniser, debounce counter, stable value db and a db rise pulse.
// Latency: raw change sampled at edge t reaches db at edge t+DEBOUNCE+1; db_rise is high that cycle.
// Backpressure: none; the filter free-runs every clock.
// Ports: clk, rst_n (async active-low), raw (asynchronous pad input),
//        db (debounced level), db_rise (one-cycle pulse coincident with db going 0->1).
module pe_bit_filter #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic db_rise
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic             s_meta;
  logic             s;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The synchronised sample has disagreed with db for DEBOUNCE consecutive cycles.
  assign accept = (s != db) && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_meta  <= 1'b0;
      s       <= 1'b0;
      db      <= 1'b0;
      cnt     <= '0;
      db_rise <= 1'b0;
    end else begin
      s_meta  <= raw;
      s       <= s_meta;
      db_rise <= accept & s;
      if (s == db) begin
        cnt <= '0;
      end else if (accept) begin
        db  <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pe_req_conditioner.sv
// Conditions raw pad requests into a clean 8-bit vector (bit 0 highest priority) for the priority encoder.
// Latency: raw change sampled at edge t shows on req_o after edge t+DEBOUNCE+2; en_i gates req_o combinationally.
// Backpressure: none; edge requests stay pending until cleared through clr_i.
// Ports: wb_clk_i, wb_rst_ni (async active-low), bus (slave side of pe_req_conditioner_if):
//        req_raw_i, edge_mode_i, clr_i, en_i in; req_o, any_o, ovf_o, new_o out.
module pe_req_conditioner
  import pe_pkg::*;
#(
  parameter int WIDTH    = PE_WIDTH,
  parameter int DEBOUNCE = PE_DEBOUNCE_DEFAULT
) (
  input logic                  wb_clk_i,
  input logic                  wb_rst_ni,
  pe_req_conditioner_if.slave  bus
);

  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] db_rise;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] p_nxt;
  logic [WIDTH-1:0] p_d;
  logic [WIDTH-1:0] ovf;
  logic [WIDTH-1:0] ovf_nxt;
  logic             new_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pe_bit_filter #(
      .DEBOUNCE (DEBOUNCE)
    ) u_filt (
      .clk     (wb_clk_i),
      .rst_n   (wb_rst_ni),
      .raw     (bus.req_raw_i[i]),
      .db      (db[i]),
      .db_rise (db_rise[i])
    );
  end

  always_comb begin
    p_nxt   = p;
    ovf_nxt = ovf;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.edge_mode_i[i] == PE_MODE_EDGE) begin
        // A new edge beats a simultaneous clear.
        p_nxt[i]   = db_rise[i] | (p[i] & ~bus.clr_i[i]);
        // When clear and edge coincide the clear retires the old request and
        // the edge becomes the pending one, so nothing was lost.
        ovf_nxt[i] = ~bus.clr_i[i] & (ovf[i] | (db_rise[i] & p[i]));
      end else begin
        p_nxt[i]   = db[i];
        ovf_nxt[i] = ovf[i] & ~bus.clr_i[i];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      p     <= '0;
      p_d   <= '0;
      ovf   <= '0;
      new_q <= 1'b0;
    end else begin
      p     <= p_nxt;
      p_d   <= p;
      ovf   <= ovf_nxt;
      // Looks at the already-registered p so the pulse lands one edge after p rises.
      new_q <= |(p & ~p_d);
    end
  end

  assign bus.req_o = p & {WIDTH{bus.en_i}};
  assign bus.any_o = |bus.req_o;
  assign bus.ovf_o = ovf;
  assign bus.new_o = new_q;

endmodule

// File: tb/tb_pe_req_conditioner.sv
module tb_pe_req_conditioner;
  import pe_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [7:0] exp_q[$];

  pe_req_conditioner_if #(.WIDTH(8)) bus ();

  pe_req_conditioner #(
    .WIDTH    (8),
    .DEBOUNCE (4)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock; outputs sampled 1 ns after the edge. Every new_o pulse pops the
  // next expected req_o snapshot from the scoreboard.
  task automatic tick();
    logic [7:0] e;
    @(posedge clk);
    #1;
    if (bus.new_o === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL new_pulse: new_o=1 unexpected, req_o=%h", bus.req_o);
      end else begin
        e = exp_q.pop_front();
        if (bus.req_o !== e) begin
          fails++;
          $display("FAIL new_pulse: req_o=%h at new_o, expected %h", bus.req_o, e);
        end
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse(input logic [7:0] v, input int n);
    bus.req_raw_i = v;
    ticks(n);
    bus.req_raw_i = 8'h00;
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.req_raw_i   = 8'h00;
    bus.edge_mode_i = {8{PE_MODE_LEVEL}};
    bus.clr_i       = 8'h00;
    bus.en_i        = 1'b1;
    ticks(3);
    chk8("reset_req", bus.req_o, 8'h00);
    chk8("reset_ovf", bus.ovf_o, 8'h00);
    chk8("reset_any_new", {6'd0, bus.any_o, bus.new_o}, 8'h00);
    rst_n = 1'b1;
    ticks(2);
  endtask

  task automatic test_level();
    bus.req_raw_i = 8'h10;
    exp_q.push_back(8'h10);
    ticks(6);
    chk8("level_rise_early", bus.req_o, 8'h00);
    tick();
    chk8("level_rise", bus.req_o, 8'h10);
    chk8("level_any", {7'd0, bus.any_o}, 8'h01);
    bus.req_raw_i = 8'h00;
    ticks(6);
    chk8("level_fall_early", bus.req_o, 8'h10);
    tick();
    chk8("level_fall", bus.req_o, 8'h00);
    ticks(2);
  endtask

  task automatic test_glitch();
    pulse(8'h04, 3);
    tick();
    chk8("glitch_cnt_mid", 8'(dut.g_bit[2].u_filt.cnt), 8'h02);
    ticks(10);
    chk8("glitch_req", bus.req_o, 8'h00);
    chk8("glitch_cnt_end", 8'(dut.g_bit[2].u_filt.cnt), 8'h00);
    bus.edge_mode_i = 8'h04;
    exp_q.push_back(8'h04);
    pulse(8'h04, 4);
    ticks(12);
    chk8("glitch_edge_latched", bus.req_o, 8'h04);
    bus.clr_i = 8'h04;
    tick();
    bus.clr_i = 8'h00;
    chk8("glitch_edge_cleared", bus.req_o, 8'h00);
  endtask

  task automatic test_edge_clear();
    bus.edge_mode_i = 8'h01;
    exp_q.push_back(8'h01);
    pulse(8'h01, 10);
    ticks(12);
    chk8("edge_held_after_fall", bus.req_o, 8'h01);
    bus.clr_i = 8'h01;
    tick();
    bus.clr_i = 8'h00;
    chk8("edge_clr", bus.req_o, 8'h00);
    chk8("edge_no_ovf", bus.ovf_o, 8'h00);
  endtask

  task automatic test_overflow();
    bus.edge_mode_i = 8'h20;
    exp_q.push_back(8'h20);
    pulse(8'h20, 6);
    ticks(12);
    chk8("ovf_first_pending", bus.req_o, 8'h20);
    chk8("ovf_first_none", bus.ovf_o, 8'h00);
    pulse(8'h20, 6);
    ticks(12);
    chk8("ovf_set", bus.ovf_o, 8'h20);
    bus.clr_i = 8'h20;
    tick();
    bus.clr_i = 8'h00;
    chk8("ovf_clr_req", bus.req_o, 8'h00);
    chk8("ovf_clr_ovf", bus.ovf_o, 8'h00);
    exp_q.push_back(8'h20);
    pulse(8'h20, 6);
    ticks(12);
    // Pending again; now land the clear exactly on the edge where the next rise sets p.
    bus.req_raw_i = 8'h20;
    ticks(6);
    bus.req_raw_i = 8'h00;
    bus.clr_i     = 8'h20;
    tick();
    bus.clr_i = 8'h00;
    chk8("ovf_coincide_req", bus.req_o, 8'h20);
    chk8("ovf_coincide_ovf", bus.ovf_o, 8'h00);
    ticks(12);
    chk8("ovf_coincide_settled", bus.ovf_o, 8'h00);
  endtask

  task automatic test_gating();
    bus.edge_mode_i = 8'hFF;
    bus.clr_i       = 8'hFF;
    tick();
    bus.clr_i = 8'h00;
    chk8("gate_cleared", bus.req_o, 8'h00);
    exp_q.push_back(8'h81);
    pulse(8'h81, 6);
    ticks(12);
    chk8("gate_pending", bus.req_o, 8'h81);
    bus.en_i = 1'b0;
    #1;
    chk8("gate_off_req", bus.req_o, 8'h00);
    chk8("gate_off_any", {7'd0, bus.any_o}, 8'h00);
    bus.en_i = 1'b1;
    #1;
    chk8("gate_on_req", bus.req_o, 8'h81);
  endtask

  task automatic test_reset_mid();
    bus.req_raw_i = 8'h02;
    ticks(3);
    chk8("rst_mid_cnt_running", 8'(dut.g_bit[1].u_filt.cnt), 8'h01);
    rst_n = 1'b0;
    #1;
    chk8("rst_mid_req", bus.req_o, 8'h00);
    chk8("rst_mid_any_new", {6'd0, bus.any_o, bus.new_o}, 8'h00);
    chk8("rst_mid_cnt", 8'(dut.g_bit[1].u_filt.cnt), 8'h00);
    ticks(2);
    rst_n = 1'b1;
    exp_q.push_back(8'h02);
    ticks(6);
    chk8("rst_release_early", bus.req_o, 8'h00);
    tick();
    chk8("rst_release_edge", bus.req_o, 8'h02);
    ticks(3);
    bus.req_raw_i = 8'h00;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_level();
    test_glitch();
    test_edge_clear();
    test_overflow();
    test_gating();
    test_reset_mid();
    ticks(4);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL new_pulse_missing: %0d expected pulses not seen, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
